// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
// No logic; pure declarations.
// No flow control; consumers decide how they use these.
package pipe_pkg;

  // Occupancy of the stage when the skid entry is built in.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // Instruction presented when no beat is held; truncated to INS_W at use.
  localparam logic [63:0] PIPE_NOP_INS = 64'd0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Latency: count changes on the rising edge after inc is sampled.
// No flow control; sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Clear wins; otherwise count up until every bit is set.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline register stage with valid/ready on both sides and a saturating stall counter.
// Latency: 1 cycle from input acceptance to output when empty; PIPE_STAGE_SKID_EN adds a skid entry.
// Backpressure: skid build registers in_ready (low only when FULL); default build uses in_ready = !out_valid || out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 INS_W   = 32,
  parameter int                 PC_W    = 32,
  parameter int                 CNT_W   = 16,
  parameter logic [INS_W-1:0]   NOP_INS = INS_W'(PIPE_NOP_INS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INS_W-1:0] in_ins,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INS_W-1:0] out_ins,
  output logic [PC_W-1:0]  out_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             in_xfer;
  logic             out_xfer;
  logic [INS_W-1:0] main_ins;
  logic [PC_W-1:0]  main_pc;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  stage_state_t     state;
  stage_state_t     state_nxt;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;
  logic [INS_W-1:0] skid_ins;
  logic [PC_W-1:0]  skid_pc;

  // in_ready decodes straight from the state flop, so it never depends on out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);

  // Occupancy register; reset beats flush, flush beats any transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next occupancy and which storage entry loads this cycle.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nxt    = HALF;
            load_main_in = 1'b1;
          end
        end
        HALF: begin
          if (in_xfer && !out_xfer) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_nxt      = HALF;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Data entries carry no reset; out_valid masks whatever they hold.
  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_ins <= in_ins;
      main_pc  <= in_pc;
    end else if (load_main_skid) begin
      main_ins <= skid_ins;
      main_pc  <= skid_pc;
    end
    if (load_skid) begin
      skid_ins <= in_ins;
      skid_pc  <= in_pc;
    end
  end
`else
  logic held;

  // A new beat may enter whenever the current one is leaving or there is none.
  assign in_ready  = !held || out_ready;
  assign out_valid = held;

  // Single-entry occupancy; reset beats flush, flush beats any transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      held <= 1'b0;
    end else if (flush) begin
      held <= 1'b0;
    end else if (in_xfer) begin
      held <= 1'b1;
    end else if (out_xfer) begin
      held <= 1'b0;
    end
  end

  // Data entry carries no reset; out_valid masks whatever it holds.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      main_ins <= in_ins;
      main_pc  <= in_pc;
    end
  end
`endif

  assign out_ins = out_valid ? main_ins : NOP_INS;
  assign out_pc  = out_valid ? main_pc  : '0;

  pipe_sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (out_valid && !out_ready),
    .cnt   (stall_cnt)
  );

endmodule
